// File: rtl/pic_bus_ctrl_seq.sv
// pic_bus_ctrl_seq
// Clocked data-bus / read-write control front end for the PIC.
// The CPU bus pins are brought into the clk domain through a configurable
// synchroniser. Each write is committed on the rising edge of wr_n and then
// decoded against the ICW1..ICW4 initialisation state machine. The decode
// produces one-cycle, mutually exclusive register strobes.
//
// Parameters:
//   SYNC_STAGES : synchroniser depth on all bus pins (0 = already synchronous)
//   CASCADE_EN  : 1 = expect ICW3 when ICW1.SNGL=0, 0 = never expect ICW3
//
// Ports:
//   clk, reset         : system clock, asynchronous active-high reset
//   cs_n, rd_n, wr_n   : CPU bus strobes (active-low)
//   a0, din[7:0]       : CPU register address bit and write data
//   cmd_data[7:0]      : byte of the last committed (decoded) write
//   icw1..icw4         : one-cycle initialisation command word strobes
//   ocw1..ocw3         : one-cycle operation command word strobes
//   init_done          : high when the init sequence is complete (READY)
//   single_mode, ic4   : SNGL and IC4 bits latched from ICW1
//   rd_active          : read in progress (rd and cs low, wr high)
//   rd_start, rd_a0    : pulse on read start, and a0 captured at that moment
module pic_bus_ctrl_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          CASCADE_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] cmd_data,
    output logic       icw1,
    output logic       icw2,
    output logic       icw3,
    output logic       icw4,
    output logic       ocw1,
    output logic       ocw2,
    output logic       ocw3,
    output logic       init_done,
    output logic       single_mode,
    output logic       ic4,
    output logic       rd_active,
    output logic       rd_start,
    output logic       rd_a0
);

    // Bus word layout: {cs_n, rd_n, wr_n, a0, din}. The idle value keeps
    // every strobe deasserted so reset never creates a phantom edge.
    localparam logic [11:0] BUS_IDLE = 12'hE00;

    logic [11:0] bus_raw;
    logic [11:0] bus_s;
    assign bus_raw = {cs_n, rd_n, wr_n, a0, din};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign bus_s = bus_raw;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][11:0] sync_q;
            logic [SYNC_STAGES-1:0][11:0] sync_d;

            always_comb begin
                sync_d[0] = bus_raw;
                for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) sync_q <= {SYNC_STAGES{BUS_IDLE}};
                else       sync_q <= sync_d;
            end

            assign bus_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic       cs_s, rd_s, wr_s, a0_s;
    logic [7:0] din_s;
    assign {cs_s, rd_s, wr_s, a0_s, din_s} = bus_s;

    // ---------------- write capture and commit ----------------
    logic       sel_q, sel_d;
    logic       cap_a0_q, cap_a0_d;
    logic [7:0] cap_din_q, cap_din_d;
    logic       wr_d_q, wr_d_d;
    logic       commit_q, commit_d;

    // sel follows the latest low-wr cycle, so cs going high before wr rises
    // aborts the write. The capture register only changes while wr_s is low,
    // so it is still stable in the cycle commit_q is decoded.
    always_comb begin
        sel_d     = sel_q;
        cap_a0_d  = cap_a0_q;
        cap_din_d = cap_din_q;
        if (!wr_s) begin
            sel_d = ~cs_s;
            if (!cs_s) begin
                cap_a0_d  = a0_s;
                cap_din_d = din_s;
            end
        end
        wr_d_d   = wr_s;
        commit_d = wr_s & ~wr_d_q & sel_q;
    end

    // ---------------- init state machine ----------------
    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] strobe_q, strobe_d;   // {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1}
    logic [7:0] cmd_data_q, cmd_data_d;
    logic       single_mode_q, single_mode_d;
    logic       ic4_q, ic4_d;
    logic       is_icw1;

    // ICW1 is recognised from any state, including mid-init and READY.
    assign is_icw1 = ~cap_a0_q & cap_din_q[4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= UNINIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (commit_q) begin
            if (is_icw1) begin
                state_d = WAIT_ICW2;
            end else begin
                case (state_q)
                    WAIT_ICW2: if (cap_a0_q) begin
                        if (CASCADE_EN && !single_mode_q) state_d = WAIT_ICW3;
                        else if (ic4_q)                   state_d = WAIT_ICW4;
                        else                              state_d = READY;
                    end
                    WAIT_ICW3: if (cap_a0_q) state_d = ic4_q ? WAIT_ICW4 : READY;
                    WAIT_ICW4: if (cap_a0_q) state_d = READY;
                    default:   state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        strobe_d      = 7'd0;
        single_mode_d = single_mode_q;
        ic4_d         = ic4_q;
        if (commit_q) begin
            if (is_icw1) begin
                strobe_d[0]   = 1'b1;
                single_mode_d = cap_din_q[1];
                ic4_d         = cap_din_q[0];
            end else begin
                case (state_q)
                    WAIT_ICW2: strobe_d[1] = cap_a0_q;
                    WAIT_ICW3: strobe_d[2] = cap_a0_q;
                    WAIT_ICW4: strobe_d[3] = cap_a0_q;
                    READY: begin
                        if (cap_a0_q)          strobe_d[4] = 1'b1;
                        else if (cap_din_q[3]) strobe_d[6] = 1'b1;
                        else                   strobe_d[5] = 1'b1;
                    end
                    default: strobe_d = 7'd0;
                endcase
            end
        end
        // Ignored writes leave cmd_data untouched.
        cmd_data_d = (|strobe_d) ? cap_din_q : cmd_data_q;
    end

    // ---------------- read tracking ----------------
    logic rd_active_q, rd_active_d;
    logic rd_start_q, rd_start_d;
    logic rd_a0_q, rd_a0_d;

    // Requiring wr_s high keeps rd_active low while a write is in flight.
    always_comb begin
        rd_active_d = ~rd_s & ~cs_s & wr_s;
        rd_start_d  = rd_active_d & ~rd_active_q;
        rd_a0_d     = rd_start_d ? a0_s : rd_a0_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q         <= 1'b0;
            cap_a0_q      <= 1'b0;
            cap_din_q     <= 8'h00;
            wr_d_q        <= 1'b1;
            commit_q      <= 1'b0;
            strobe_q      <= 7'd0;
            cmd_data_q    <= 8'h00;
            single_mode_q <= 1'b0;
            ic4_q         <= 1'b0;
            rd_active_q   <= 1'b0;
            rd_start_q    <= 1'b0;
            rd_a0_q       <= 1'b0;
        end else begin
            sel_q         <= sel_d;
            cap_a0_q      <= cap_a0_d;
            cap_din_q     <= cap_din_d;
            wr_d_q        <= wr_d_d;
            commit_q      <= commit_d;
            strobe_q      <= strobe_d;
            cmd_data_q    <= cmd_data_d;
            single_mode_q <= single_mode_d;
            ic4_q         <= ic4_d;
            rd_active_q   <= rd_active_d;
            rd_start_q    <= rd_start_d;
            rd_a0_q       <= rd_a0_d;
        end
    end

    assign {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1} = strobe_q;
    assign cmd_data    = cmd_data_q;
    assign init_done   = (state_q == READY);
    assign single_mode = single_mode_q;
    assign ic4         = ic4_q;
    assign rd_active   = rd_active_q;
    assign rd_start    = rd_start_q;
    assign rd_a0       = rd_a0_q;

endmodule

// File: tb/tb_pic_bus_ctrl_seq.sv
// Testbench for pic_bus_ctrl_seq: a table of directed writes applied to a
// cascade-enabled instance and a CASCADE_EN=0 instance in parallel, plus
// hand-written sequences for abort, asynchronous reset and read handling.
module tb_pic_bus_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
    logic [7:0] din = 8'h00;

    always #5 clk = ~clk;

    // instance 0: CASCADE_EN=1
    logic [7:0] cmd0;
    logic       i1_0, i2_0, i3_0, i4_0, o1_0, o2_0, o3_0;
    logic       init0, sm0, ic40, rda0, rds0, rdaa0;
    // instance 1: CASCADE_EN=0
    logic [7:0] cmd1;
    logic       i1_1, i2_1, i3_1, i4_1, o1_1, o2_1, o3_1;
    logic       init1, sm1, ic41, rda1, rds1, rdaa1;

    pic_bus_ctrl_seq #(.SYNC_STAGES(2), .CASCADE_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .a0(a0), .din(din), .cmd_data(cmd0),
        .icw1(i1_0), .icw2(i2_0), .icw3(i3_0), .icw4(i4_0),
        .ocw1(o1_0), .ocw2(o2_0), .ocw3(o3_0),
        .init_done(init0), .single_mode(sm0), .ic4(ic40),
        .rd_active(rda0), .rd_start(rds0), .rd_a0(rdaa0));

    pic_bus_ctrl_seq #(.SYNC_STAGES(2), .CASCADE_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .a0(a0), .din(din), .cmd_data(cmd1),
        .icw1(i1_1), .icw2(i2_1), .icw3(i3_1), .icw4(i4_1),
        .ocw1(o1_1), .ocw2(o2_1), .ocw3(o3_1),
        .init_done(init1), .single_mode(sm1), .ic4(ic41),
        .rd_active(rda1), .rd_start(rds1), .rd_a0(rdaa1));

    logic [6:0] st0, st1;
    assign st0 = {o3_0, o2_0, o1_0, i4_0, i3_0, i2_0, i1_0};
    assign st1 = {o3_1, o2_1, o1_1, i4_1, i3_1, i2_1, i1_1};

    localparam logic [6:0] NONE = 7'h00, ICW1 = 7'h01, ICW2 = 7'h02, ICW3 = 7'h04,
                           ICW4 = 7'h08, OCW1 = 7'h10, OCW2 = 7'h20, OCW3 = 7'h40;
    localparam int STROBE_LAT = 4;  // negedges from wr_n rise to strobe (2 sync + commit + strobe reg)

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete bus write; strobes are sampled on every negedge.
    task automatic do_write(input logic a, input logic [7:0] d, input logic with_rd,
                            output logic [6:0] or0, output logic [6:0] or1,
                            output int ones0, output int lat0,
                            output logic init_at, output logic rd_seen);
        or0 = '0; or1 = '0; ones0 = 0; lat0 = -1; init_at = 1'b0; rd_seen = 1'b0;
        @(negedge clk);
        cs_n = 1'b0; a0 = a; din = d; wr_n = 1'b0; rd_n = ~with_rd;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rd_seen |= rda0;
            ones0 += $countones(st0);
            or0 |= st0; or1 |= st1;
        end
        wr_n = 1'b1; rd_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            rd_seen |= rda0;
            if (st0 != 7'd0 && lat0 < 0) begin
                lat0 = k;
                init_at = init0;
            end
            ones0 += $countones(st0);
            or0 |= st0; or1 |= st1;
            if (k == 2) cs_n = 1'b1;
        end
    endtask

    typedef struct {
        logic       a;
        logic [7:0] d;
        logic [6:0] s0;    // expected strobe, CASCADE_EN=1
        logic [6:0] s1;    // expected strobe, CASCADE_EN=0
        logic [7:0] cmd;
        logic       init;
        logic       sm;
        logic       ic4;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [6:0] or0, or1;
        int         ones0, lat0, nstart;
        logic       init_at, rd_seen;

        tbl[0]  = '{1'b1, 8'hFF, NONE, NONE, 8'h00, 1'b0, 1'b0, 1'b0}; // UNINIT ignores
        tbl[1]  = '{1'b0, 8'h20, NONE, NONE, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'h13, ICW1, ICW1, 8'h13, 1'b0, 1'b1, 1'b1}; // single, IC4
        tbl[3]  = '{1'b1, 8'h20, ICW2, ICW2, 8'h20, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 8'h01, ICW4, ICW4, 8'h01, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 8'hFB, OCW1, OCW1, 8'hFB, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 8'h20, OCW2, OCW2, 8'h20, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 8'h0A, OCW3, OCW3, 8'h0A, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 8'h11, ICW1, ICW1, 8'h11, 1'b0, 1'b0, 1'b1}; // cascade, IC4
        tbl[9]  = '{1'b1, 8'h08, ICW2, ICW2, 8'h08, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 8'h04, ICW3, ICW4, 8'h04, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 8'h01, ICW4, OCW1, 8'h01, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 8'h13, ICW1, ICW1, 8'h13, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 8'h20, NONE, NONE, 8'h13, 1'b0, 1'b1, 1'b1}; // ignored in WAIT_ICW2
        tbl[14] = '{1'b1, 8'h20, ICW2, ICW2, 8'h20, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 8'h05, ICW4, ICW4, 8'h05, 1'b1, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 8'h16, ICW1, ICW1, 8'h16, 1'b0, 1'b1, 1'b0}; // single, no IC4
        tbl[17] = '{1'b1, 8'h40, ICW2, ICW2, 8'h40, 1'b1, 1'b1, 1'b0}; // straight to READY

        // reset state
        repeat (3) @(negedge clk);
        chk("reset strobes", 32'(st0), 32'(0));
        chk("reset cmd_data", 32'(cmd0), 32'(0));
        chk("reset flags", 32'({init0, sm0, ic40, rda0, rds0, rdaa0}), 32'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            do_write(tbl[i].a, tbl[i].d, 1'b0, or0, or1, ones0, lat0, init_at, rd_seen);
            $display("vec %0d: a0=%0d din=%02h strobes0=%b strobes1=%b cmd=%02h init=%0d",
                     i, tbl[i].a, tbl[i].d, or0, or1, cmd0, init0);
            chk($sformatf("v%0d strobe0", i), 32'(or0), 32'(tbl[i].s0));
            chk($sformatf("v%0d strobe1", i), 32'(or1), 32'(tbl[i].s1));
            chk($sformatf("v%0d pulses", i), 32'(ones0), 32'((tbl[i].s0 != NONE) ? 1 : 0));
            chk($sformatf("v%0d cmd", i), 32'(cmd0), 32'(tbl[i].cmd));
            chk($sformatf("v%0d flags", i), 32'({init0, sm0, ic40}),
                32'({tbl[i].init, tbl[i].sm, tbl[i].ic4}));
            if (tbl[i].s0 != NONE) begin
                chk($sformatf("v%0d latency", i), 32'(lat0), 32'(STROBE_LAT));
                chk($sformatf("v%0d init_at_strobe", i), 32'(init_at), 32'(tbl[i].init));
            end
        end

        // write aborted by cs_n rising while wr_n is still low
        @(negedge clk);
        cs_n = 1'b0; a0 = 1'b1; din = 8'hAA; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        wr_n = 1'b1;
        ones0 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ones0 += $countones(st0);
        end
        $display("abort: pulses=%0d cmd=%02h", ones0, cmd0);
        chk("abort pulses", 32'(ones0), 32'(0));
        chk("abort cmd", 32'(cmd0), 32'(8'h40));

        // asynchronous reset while in WAIT_ICW3
        do_write(1'b0, 8'h11, 1'b0, or0, or1, ones0, lat0, init_at, rd_seen);
        do_write(1'b1, 8'h08, 1'b0, or0, or1, ones0, lat0, init_at, rd_seen);
        chk("pre-reset ic4", 32'(ic40), 32'(1));
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        $display("async reset: cmd=%02h init=%0d ic4=%0d", cmd0, init0, ic40);
        chk("async reset cmd", 32'(cmd0), 32'(0));
        chk("async reset flags", 32'({st0, init0, sm0, ic40, rda0, rds0, rdaa0}), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        do_write(1'b1, 8'h04, 1'b0, or0, or1, ones0, lat0, init_at, rd_seen);
        $display("post-reset a0=1 write: strobes=%b cmd=%02h", or0, cmd0);
        chk("post-reset ignored", 32'(ones0), 32'(0));
        chk("post-reset cmd", 32'(cmd0), 32'(0));

        // rd_n and wr_n low together: write commits, no read seen
        do_write(1'b0, 8'h13, 1'b1, or0, or1, ones0, lat0, init_at, rd_seen);
        $display("rd+wr: strobes=%b rd_seen=%0d", or0, rd_seen);
        chk("rd+wr strobe", 32'(or0), 32'(ICW1));
        chk("rd+wr rd_active", 32'(rd_seen), 32'(0));

        // plain read with a0=1
        @(negedge clk);
        cs_n = 1'b0; a0 = 1'b1; rd_n = 1'b0;
        nstart = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            nstart += int'(rds0);
        end
        $display("read: rd_active=%0d rd_start pulses=%0d rd_a0=%0d", rda0, nstart, rdaa0);
        chk("read rd_active", 32'(rda0), 32'(1));
        chk("read rd_start count", 32'(nstart), 32'(1));
        chk("read rd_a0", 32'(rdaa0), 32'(1));
        rd_n = 1'b1; cs_n = 1'b1; a0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("read end rd_active", 32'(rda0), 32'(0));
        chk("read end rd_a0 held", 32'(rdaa0), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
